// File: rtl/solomon_vram_arbiter.sv
// Single-port VRAM arbiter: video > sprite > CPU, with a CPU starvation override.
// Optional wait/peak statistics are built when SOLOMON_VRAM_ARB_STATS_EN is defined.
module solomon_vram_arbiter #(
  parameter int AW          = 11,
  parameter int DW          = 8,
  parameter int RAM_LAT     = 1,
  parameter int CPU_MAXWAIT = 6
) (
  input  logic          VCLKx4,
  input  logic          RESET,
  input  logic          VREQ,
  input  logic [AW-1:0] VAD,
  output logic          VACK,
  output logic          VDV,
  output logic [DW-1:0] VDT,
  input  logic          SREQ,
  input  logic [AW-1:0] SAD,
  output logic          SACK,
  output logic          SDV,
  output logic [DW-1:0] SDT,
  input  logic          CREQ,
  input  logic          CWR,
  input  logic [AW-1:0] CAD,
  input  logic [DW-1:0] CID,
  output logic          CWAIT,
  output logic          CDV,
  output logic [DW-1:0] COD,
  output logic [AW-1:0] RAD,
  output logic          RWE,
  output logic [DW-1:0] RWD,
`ifdef SOLOMON_VRAM_ARB_STATS_EN
  input  logic          STAT_CLR,
  output logic [15:0]   STAT_WAIT,
  output logic [3:0]    STAT_PEAK,
`endif
  input  logic [DW-1:0] RRD
);

  localparam int CW = 4;

  typedef enum logic [1:0] {
    OWN_V = 2'd0,
    OWN_S = 2'd1,
    OWN_C = 2'd2
  } own_t;

  typedef struct packed {
    logic vld;
    own_t own;
  } tag_t;

  logic [CW-1:0] cnt;
  logic          done;
  logic          c_elig;
  logic          starve;
  logic          gv, gs, gc;
  logic          g_any;
  logic [AW-1:0] g_addr;
  tag_t          new_tag;
  tag_t [RAM_LAT:0] tags;

  assign c_elig = CREQ & ~done;
  assign starve = c_elig & (cnt == CW'(CPU_MAXWAIT));

  always_comb begin
    gv = 1'b0;
    gs = 1'b0;
    gc = 1'b0;
    priority case (1'b1)
      starve:  gc = 1'b1;
      VREQ:    gv = 1'b1;
      SREQ:    gs = 1'b1;
      c_elig:  gc = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    g_addr      = CAD;
    new_tag.vld = 1'b0;
    new_tag.own = OWN_C;
    if (gv) begin
      g_addr      = VAD;
      new_tag.vld = 1'b1;
      new_tag.own = OWN_V;
    end else if (gs) begin
      g_addr      = SAD;
      new_tag.vld = 1'b1;
      new_tag.own = OWN_S;
    end else if (gc) begin
      new_tag.vld = ~CWR;
    end
  end

  assign g_any = gv | gs | gc;
  assign VACK  = gv;
  assign SACK  = gs;
  assign CWAIT = CREQ & ~done & ~gc;

  always_ff @(posedge VCLKx4 or posedge RESET) begin
    if (RESET) begin
      RAD  <= '0;
      RWE  <= 1'b0;
      RWD  <= '0;
      tags <= '0;
      VDV  <= 1'b0;
      SDV  <= 1'b0;
      CDV  <= 1'b0;
      VDT  <= '0;
      SDT  <= '0;
      COD  <= '0;
      done <= 1'b0;
      cnt  <= '0;
    end else begin
      RWE <= gc & CWR;
      if (g_any) begin
        RAD <= g_addr;
        RWD <= CID;
      end
      tags[0] <= new_tag;
      for (int i = 1; i <= RAM_LAT; i++) tags[i] <= tags[i-1];
      // Tag leaving the pipe lines up with RRD for its own address
      VDV <= 1'b0;
      SDV <= 1'b0;
      CDV <= 1'b0;
      if (tags[RAM_LAT].vld) begin
        case (tags[RAM_LAT].own)
          OWN_V: begin VDV <= 1'b1; VDT <= RRD; end
          OWN_S: begin SDV <= 1'b1; SDT <= RRD; end
          default: begin CDV <= 1'b1; COD <= RRD; end
        endcase
      end
      if (!CREQ)   done <= 1'b0;
      else if (gc) done <= 1'b1;
      if (!CREQ || gc)
        cnt <= '0;
      else if (c_elig && cnt != CW'(CPU_MAXWAIT))
        cnt <= cnt + 1'b1;
    end
  end

`ifdef SOLOMON_VRAM_ARB_STATS_EN
  always_ff @(posedge VCLKx4 or posedge RESET) begin
    if (RESET) begin
      STAT_WAIT <= '0;
      STAT_PEAK <= '0;
    end else if (STAT_CLR) begin
      STAT_WAIT <= '0;
      STAT_PEAK <= '0;
    end else begin
      if (CWAIT && STAT_WAIT != 16'hFFFF) STAT_WAIT <= STAT_WAIT + 1'b1;
      if (cnt > STAT_PEAK) STAT_PEAK <= cnt;
    end
  end
`endif

endmodule

// File: tb/tb_solomon_vram_arbiter.sv
// Bench for solomon_vram_arbiter: RAM model, per-cycle reference model and
// directed scenarios with literal expectations.
module tb_solomon_vram_arbiter;

  localparam int AW = 11;
  localparam int DW = 8;

  logic          clk   = 1'b0;
  logic          rst   = 1'b1;
  logic          vreq  = 1'b0;
  logic [AW-1:0] vad   = '0;
  logic          sreq  = 1'b0;
  logic [AW-1:0] sad   = '0;
  logic          creq  = 1'b0;
  logic          cwr   = 1'b0;
  logic [AW-1:0] cad   = '0;
  logic [DW-1:0] cid   = '0;
  logic [DW-1:0] rrd;
  logic          vack, vdv, sack, sdv, cwait, cdv, rwe;
  logic [DW-1:0] vdt, sdt, cod, rwd;
  logic [AW-1:0] rad;
`ifdef SOLOMON_VRAM_ARB_STATS_EN
  logic          stat_clr = 1'b0;
  logic [15:0]   stat_wait;
  logic [3:0]    stat_peak;
`endif

  solomon_vram_arbiter dut (
    .VCLKx4(clk), .RESET(rst),
    .VREQ(vreq), .VAD(vad), .VACK(vack), .VDV(vdv), .VDT(vdt),
    .SREQ(sreq), .SAD(sad), .SACK(sack), .SDV(sdv), .SDT(sdt),
    .CREQ(creq), .CWR(cwr), .CAD(cad), .CID(cid),
    .CWAIT(cwait), .CDV(cdv), .COD(cod),
    .RAD(rad), .RWE(rwe), .RWD(rwd),
`ifdef SOLOMON_VRAM_ARB_STATS_EN
    .STAT_CLR(stat_clr), .STAT_WAIT(stat_wait), .STAT_PEAK(stat_peak),
`endif
    .RRD(rrd)
  );

  always #5 clk = ~clk;

  // Synchronous RAM macro, one cycle read latency
  logic [DW-1:0] mem [2048];
  always @(posedge clk) begin
    if (rwe) mem[rad] <= rwd;
    rrd <= mem[rad];
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: grants in arrival order, returns scheduled 3 cycles on
  typedef struct {
    int            due;
    int            own;
    logic [DW-1:0] d;
  } ev_t;

  ev_t           q[$];
  logic [DW-1:0] sh [2048];
  int            cyc = 0;
  int            m_cnt = 0;
  bit            m_done = 0;
  logic [AW-1:0] e_rad = '0;
  logic          e_rwe = 1'b0;
  logic [DW-1:0] e_rwd = '0, e_vdt = '0, e_sdt = '0, e_cod = '0;

  always @(negedge clk) begin
    bit pv, ps, pc, elig, st, mv, ms, mc;
    if (rst) begin
      q.delete();
      m_cnt  = 0;
      m_done = 0;
      e_rad  = '0;
      e_rwe  = 1'b0;
      e_rwd  = '0;
      e_vdt  = '0;
      e_sdt  = '0;
      e_cod  = '0;
      chk("m_rst_rad", rad, 0);
      chk("m_rst_dv", {vdv, sdv, cdv, rwe}, 0);
      chk("m_rst_dt", {vdt, sdt, cod, rwd}, 0);
    end else begin
      pv = 0; ps = 0; pc = 0;
      if (q.size() > 0 && q[0].due == cyc) begin
        case (q[0].own)
          0: begin pv = 1; e_vdt = q[0].d; end
          1: begin ps = 1; e_sdt = q[0].d; end
          default: begin pc = 1; e_cod = q[0].d; end
        endcase
        void'(q.pop_front());
      end
      chk("m_vdv", vdv, pv);
      chk("m_sdv", sdv, ps);
      chk("m_cdv", cdv, pc);
      chk("m_vdt", vdt, e_vdt);
      chk("m_sdt", sdt, e_sdt);
      chk("m_cod", cod, e_cod);
      chk("m_rad", rad, e_rad);
      chk("m_rwe", rwe, e_rwe);
      if (e_rwe) chk("m_rwd", rwd, e_rwd);
      elig = creq && !m_done;
      st   = elig && (m_cnt == 6);
      mc   = elig && (st || (!vreq && !sreq));
      mv   = vreq && !st;
      ms   = sreq && !vreq && !st;
      chk("m_vack", vack, mv);
      chk("m_sack", sack, ms);
      chk("m_cwait", cwait, elig && !mc);
      e_rwe = 1'b0;
      if (mv) begin
        e_rad = vad;
        q.push_back('{cyc + 3, 0, sh[vad]});
      end else if (ms) begin
        e_rad = sad;
        q.push_back('{cyc + 3, 1, sh[sad]});
      end else if (mc) begin
        e_rad = cad;
        if (cwr) begin
          sh[cad] = cid;
          e_rwe   = 1'b1;
          e_rwd   = cid;
        end else begin
          q.push_back('{cyc + 3, 2, sh[cad]});
        end
      end
      if (!creq || mc)             m_cnt = 0;
      else if (elig && m_cnt < 6)  m_cnt++;
      if (!creq)    m_done = 0;
      else if (mc)  m_done = 1;
    end
    cyc++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    for (int i = 0; i < 2048; i++) begin
      mem[i] = 8'(i) ^ 8'h3C;
      sh[i]  = 8'(i) ^ 8'h3C;
    end
    mem[11'h123] = 8'hA5;
    sh[11'h123]  = 8'hA5;

    @(negedge clk);
    chk("rst_rad", rad, 0);
    chk("rst_outs", {vdv, sdv, cdv, rwe, cwait}, 0);
    step(); step();
    rst = 1'b0;
    step();

    // single video read
    step(); vreq = 1; vad = 11'h123;
    @(negedge clk); chk("t1_vack", vack, 1);
    step(); vreq = 0;
    @(negedge clk); chk("t1_rad", rad, 11'h123);
    step();
    @(negedge clk); chk("t1_vdv_early", vdv, 0);
    step();
    @(negedge clk); chk("t1_vdv", vdv, 1); chk("t1_vdt", vdt, 8'hA5);
    step();
    @(negedge clk); chk("t1_vdv_pulse", vdv, 0);

    // priority V > S > C
    step(); vreq = 1; vad = 11'h100; sreq = 1; sad = 11'h101;
    creq = 1; cwr = 0; cad = 11'h050;
    @(negedge clk); chk("t2_all", {vack, sack, cwait}, 3'b101);
    step(); vreq = 0;
    @(negedge clk); chk("t2_s", {vack, sack, cwait}, 3'b011);
    step(); sreq = 0;
    @(negedge clk); chk("t2_c", {vack, sack, cwait}, 3'b000);
    step();
    @(negedge clk); chk("t2_c_hold", cwait, 0);
    step(); creq = 0;
    step();

    // starvation override
    step(); vreq = 1; vad = 11'h300;
    creq = 1; cwr = 1; cad = 11'h010; cid = 8'h5A;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); chk("t3_wait", {cwait, vack}, 2'b11);
      step();
    end
    @(negedge clk); chk("t3_grant", {cwait, vack}, 2'b00);
    step();
    @(negedge clk);
    chk("t3_rwe", rwe, 1);
    chk("t3_rad", rad, 11'h010);
    chk("t3_rwd", rwd, 8'h5A);
    chk("t3_nowait", cwait, 0);
    step();
    @(negedge clk); chk("t3_nowait2", cwait, 0);
    step(); vreq = 0; creq = 0; cwr = 0;

    // one access per CPU bus cycle
    step(); creq = 1; cad = 11'h045;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); if (cdv) n++;
      step();
    end
    creq = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); if (cdv) n++;
      step();
    end
    chk("t4_cdv_count", n, 1);
    @(negedge clk); chk("t4_cod", cod, 8'h79);

    // ordering around a CPU write
    step(); vreq = 1; vad = 11'h200;
    step(); vreq = 0; creq = 1; cwr = 1; cad = 11'h200; cid = 8'h77;
    step(); creq = 0; cwr = 0; sreq = 1; sad = 11'h200;
    step(); sreq = 0;
    repeat (5) step();
    @(negedge clk);
    chk("t5_vdt_old", vdt, 8'h3C);
    chk("t5_sdt_new", sdt, 8'h77);

    // reset with a read in flight
    step(); vreq = 1; vad = 11'h123;
    step(); vreq = 0; rst = 1;
    @(negedge clk);
    chk("t6_rad", rad, 0);
    chk("t6_vdt", vdt, 0);
    step(); step(); rst = 0;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); if (vdv) n++;
      step();
    end
    chk("t6_no_vdv", n, 0);
    vreq = 1; vad = 11'h045;
    @(negedge clk); chk("t6_vack", vack, 1);
    step(); vreq = 0;
    step(); step();
    @(negedge clk); chk("t6_vdv", vdv, 1); chk("t6_vdt", vdt, 8'h79);
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/solomon_vram_arbiter.md
Name: solomon_vram_arbiter

Overview:
Arbitrates one single-port synchronous video RAM among three requesters, all clocked on VCLKx4:
- V: tile fetch for FG/BG.
- S: sprite attribute fetch.
- C: Z80 CPU bus.

Fixed priority applies (V > S > C), with a starvation override that bounds CPU wait. The block sits between the CPU decode (CL/AD/WR/ID domain, synchronised to VCLKx4 upstream) and the VRAM macro, replacing per-requester dual-port RAMs.

Parameters:
AW, 11, RAM address width
DW, 8, RAM data width
RAM_LAT, 1, RAM read latency in VCLKx4 cycles from registered RAD to valid RRD (1..3)
CPU_MAXWAIT, 6, consecutive denied CPU cycles before CPU takes top priority (1..15)

Ports:
VCLKx4  in  1  sole clock; all logic rises on posedge
RESET  in  1  asynchronous, active-high reset
VREQ  in  1  video fetch request, per-cycle
VAD  in  AW  video address
VACK  out  1  video grant (combinational, same cycle)
VDV  out  1  video read data valid pulse
VDT  out  DW  video read data
SREQ  in  1  sprite fetch request, per-cycle
SAD  in  AW  sprite address
SACK  out  1  sprite grant (combinational)
SDV  out  1  sprite read data valid pulse
SDT  out  DW  sprite read data
CREQ  in  1  CPU bus cycle active (level, held for whole bus cycle)
CWR  in  1  CPU write when 1
CAD  in  AW  CPU address
CID  in  DW  CPU write data
CWAIT  out  1  CPU wait (combinational)
CDV  out  1  CPU read data valid pulse
COD  out  DW  CPU read data, held until next CPU read completes
RAD  out  AW  RAM address (registered)
RWE  out  1  RAM write enable (registered)
RWD  out  DW  RAM write data (registered)
RRD  in  DW  RAM read data

Behaviour:
- Reset values: RAD=0, RWE=0, RWD=0, VDT/SDT/COD=0, VDV/SDV/CDV=0; tag pipeline cleared; starvation counter=0; CPU done flag=0.
- CPU eligibility: CPU is eligible when CREQ=1 and done=0.
- Grant, computed combinationally each cycle; at most one grant per cycle:
  - Starve mode (counter==CPU_MAXWAIT) and CPU eligible: grant C.
  - Otherwise grant the first of V, S, C (in that order) that is requesting or eligible.
- ACK outputs: VACK and SACK equal their grant bits. There is no CACK port.
- CWAIT = CREQ & ~done & ~grantC.
- Edge following a grant:
  - RAD is loaded with the granted address.
  - RWE=1 only for a CPU write grant; RWD=CID.
  - With no grant: RWE=0 and RAD holds its value.
- Tag shift register, depth RAM_LAT+1, carries {valid, owner V/S/C} for read grants only. CPU writes produce no tag.
- Read return: when a tag exits, RRD is registered into the owner's DT and that owner's DV pulses high for exactly 1 cycle.
- Read latency: grant in cycle N → DV high in cycle N+2+RAM_LAT (N+3 for RAM_LAT=1).
- Back-to-back grants to the same requester are allowed every cycle; returns stay in order.
- CPU done flag:
  - Set on the edge after grantC.
  - Cleared when CREQ=0.
  - Result: one RAM access per CPU bus cycle; CWAIT stays 0 after the grant until CREQ drops.
- Starvation counter:
  - Increments (saturating at CPU_MAXWAIT) each cycle the CPU is eligible and not granted.
  - Cleared to 0 on grantC or when CREQ=0.
- Ordering: single port, so a CPU write granted after a V/S read never affects that read's data. A read granted after the write returns the new data.
- CREQ dropping while CWAIT=1: the request is abandoned. No access occurs and the counter clears.
- RESET asserted mid-operation: in-flight tags are discarded (no DV pulse); outputs go to reset values immediately.

Optional Feature:
SOLOMON_VRAM_ARB_STATS_EN
- Enabled: adds input STAT_CLR (1) and outputs STAT_WAIT (16) and STAT_PEAK (4).
  - STAT_WAIT: saturating count of cycles with CWAIT=1.
  - STAT_PEAK: maximum starvation counter value seen.
  - STAT_CLR (synchronous) zeroes both; RESET zeroes both.
- Disabled: these ports and registers do not exist. Arbitration is identical.

Test Plan:
- Read returns:
  - VREQ=1, VAD=0x123 for 1 cycle with RRD model returning 0xA5 for 0x123 → VACK=1 same cycle.
  - RAD=0x123 next cycle; VDV=1 with VDT=0xA5 exactly 3 cycles after grant (RAM_LAT=1).
- Priority:
  - VREQ, SREQ and CREQ (read) all high for 1 cycle → only VACK=1.
  - Next cycle with VREQ=0 → SACK=1.
  - Following cycle → CPU granted and CWAIT drops.
- Starvation:
  - VREQ held high continuously, CREQ=1 CWR=1 CAD=0x010 CID=0x5A → CWAIT=1 for exactly 6 cycles.
  - 7th cycle: CPU granted (VACK=0); RWE=1, RAD=0x010, RWD=0x5A next cycle; CWAIT stays 0 while CREQ held.
- Single access per bus cycle: CPU read held 10 cycles with no other requests → exactly one RAM read, one CDV pulse; COD holds data after CREQ drops.
- Ordering: grant V read of 0x200, then CPU write 0x200=0x77, then S read of 0x200 → VDT returns old value, SDT=0x77.
- Reset mid-operation: assert RESET one cycle after a V read grant → no VDV pulse, all outputs at reset values; normal grants resume after release.
